// File: rtl/handshaking_arbiter.sv
// Round-robin arbiter sharing one slave byte port among NUM_REQ requesters.
// Latches the winner's byte, drives valid, returns ack on ready or err on timeout.
module handshaking_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         slv_data,
  output logic                          slv_valid,
  input  logic                          slv_data_ready,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PW-1:0] PTR_INIT = PW'(NUM_REQ - 1);
  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [7:0]    cnt;

  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   pos;

  // Search upward from ptr+1 with wrap; pos never exceeds 2*NUM_REQ-1
  always_comb begin
    found = 1'b0;
    win   = ptr;
    pos   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_REQ))
        pos = pos - (PW+1)'(NUM_REQ);
      if (!found && req_valid[pos[PW-1:0]]) begin
        found = 1'b1;
        win   = pos[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= PTR_INIT;
      cnt      <= '0;
      grant    <= '0;
      req_ack  <= '0;
      req_err  <= '0;
      slv_data <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant    <= ONE << win;
            slv_data <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
            ptr      <= win;
            cnt      <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (slv_data_ready) begin
            req_ack <= grant;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            req_err <= grant;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (!slv_data_ready) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign slv_valid = (state == XFER);
  assign busy      = (state != IDLE);

endmodule

// File: doc/handshaking_arbiter.md
# handshaking_arbiter

Round-robin arbiter that shares one `handshaking_slave` byte port among `NUM_REQ` requesters. It latches the winning requester's byte and drives the slave's `data_in`/`data_valid` pair. It waits for the slave's `data_ready`, then returns a per-requester acknowledge, or an error on timeout. It sits between the requester blocks and the single slave instance, and is the only driver of the slave's input handshake.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: byte width; matches the slave's `data_in`.
- `TIMEOUT`, 255: cycles in XFER without `slv_data_ready` before abort (1..255).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: bit i is requester i's request; held high until ack/err.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ack`  out  NUM_REQ: one-cycle pulse on bit i when requester i's byte is accepted.
- `req_err`  out  NUM_REQ: one-cycle pulse on bit i when requester i's transfer times out.
- `grant`  out  NUM_REQ: one-hot owner during XFER/DONE; all zero otherwise.
- `slv_data`  out  DATA_WIDTH: to slave `data_in`.
- `slv_valid`  out  1: to slave `data_valid`.
- `slv_data_ready`  in  1: from slave `data_ready`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, XFER, DONE.
- Reset (`rst` low, async): state IDLE. `grant`, `req_ack`, `req_err`, `slv_valid` and `busy` are 0. `slv_data` is 0, the timeout counter is 0, and the last-grant pointer is NUM_REQ-1, so requester 0 wins first.
- IDLE: if any `req_valid` bit is set, select the first set bit searching upward from pointer+1 with wrap (round-robin).
  - Load `grant` with the winner's one-hot and latch its `req_data` into `slv_data`.
  - Set the pointer to the winner, clear the counter, and go to XFER. No request: stay in IDLE.
- XFER: `slv_valid`=1, `slv_data` held constant, counter increments each cycle.
  - `slv_data_ready` sampled 1: pulse `req_ack[winner]` and go to DONE.
  - Counter reaches TIMEOUT-1 with `slv_data_ready` 0: pulse `req_err[winner]` and go to DONE.
  - Ready and timeout on the same edge: ready wins; ack only, no err.
- DONE: `slv_valid`=0 and `grant` held. Stay until `slv_data_ready` is sampled 0 (slave released), then clear `grant` and go to IDLE.
- The latched byte is unaffected if the requester drops `req_valid` or changes `req_data` during XFER; the transfer still completes.
- The winner must drop `req_valid` within one cycle of ack/err. If it is still high in IDLE it is a new request at the lowest priority.
- Requests arriving during XFER/DONE wait; no preemption.
- Reset during XFER/DONE aborts immediately: `slv_valid` drops asynchronously, and no ack/err is issued for the aborted transfer.

## Timing
- IDLE→XFER: `req_valid` sampled at edge k; `grant`, `slv_valid` and `slv_data` valid after edge k.
- Ack latency: `slv_data_ready` sampled high at edge m gives `req_ack` high for the cycle after edge m, with `slv_valid` low at the same time.
- Timeout: `req_err` is high for the cycle after the edge at which TIMEOUT cycles of XFER have elapsed.
- Minimum transaction: 3 cycles (IDLE, XFER, DONE). Back-to-back grants are separated by at least one IDLE cycle.
- `req_ack` and `req_err` are one-hot or zero and never high together.

## Test plan
- Single request: `req_valid`=4'b0100, byte 2 = 8'hD4, slave raises `data_ready` 3 cycles after `slv_valid`.
  - Expect `grant`=4'b0100, `slv_data`=8'hD4, `req_ack`=4'b0100 for 1 cycle, `slv_valid` low in DONE, back to IDLE.
- Round-robin: all four `req_valid` held high with each requester re-asserting after its ack, bytes 8'h10..8'h13.
  - Expect grant order 0,1,2,3,0, and `slv_data` sequence 8'h10, 8'h11, 8'h12, 8'h13.
- Timeout: TIMEOUT=8, requester 1 valid, slave never ready.
  - Expect `req_err`=4'b0010 exactly 8 cycles after XFER entry, `req_ack` stays 0, then IDLE.
- Ready/timeout tie: TIMEOUT=8, slave ready sampled on the 8th XFER cycle.
  - Expect `req_ack` pulse, no `req_err`.
- Release: slave holds `data_ready` high for 5 cycles after ack.
  - Expect DONE held for those 5 cycles, `grant` held throughout, and no new `slv_valid` until after release.
- Reset mid-XFER: assert `rst` low during XFER.
  - Expect all outputs 0 asynchronously. After release with requesters 0 and 3 both valid, expect requester 0 granted first.
